// File: rtl/i2c_bit_ctrl.sv
// I2C bit sequencer: one bus command (START/STOP/WRITE/READ) becomes four prescaled phases of SCL/SDA drive.
// Latency 4*(P+1) cycles plus stretch; cmd_ready only in IDLE, SCL low in PH_B/PH_C stalls the phase.
module i2c_bit_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd,
  input  logic                  cmd_din,
  output logic                  done,
  output logic                  dout,
  output logic                  busy,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  state_t                state;
  state_t                nxt_phase;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] presc_q;
  logic [1:0]            cmd_q;
  logic                  din_q;
  logic                  stall;

  // Returns {scl_oe, sda_oe} for a command in a given phase.
  function automatic logic [1:0] phase_drive(input logic [1:0] c, input logic d, input state_t ph);
    logic scl;
    logic sda;
    scl = 1'b0;
    sda = 1'b0;
    case (c)
      CMD_START: begin
        sda = (ph == PH_C) || (ph == PH_D);
        scl = (ph == PH_D);
      end
      CMD_STOP: begin
        scl = (ph == PH_A);
        sda = (ph != PH_D);
      end
      default: begin
        scl = (ph == PH_A) || (ph == PH_D);
        sda = (c == CMD_WRITE) ? ~d : 1'b0;
      end
    endcase
    return {scl, sda};
  endfunction

  always_comb begin
    nxt_phase = IDLE;
    case (state)
      PH_A:    nxt_phase = PH_B;
      PH_B:    nxt_phase = PH_C;
      PH_C:    nxt_phase = PH_D;
      default: nxt_phase = IDLE;
    endcase
  end

  // A slave holding SCL low while we release it extends the high phases.
  assign stall     = ((state == PH_B) || (state == PH_C)) && !scl_i;
  assign cmd_ready = enable && (state == IDLE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      presc_q <= '0;
      cmd_q   <= CMD_START;
      din_q   <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      done    <= 1'b0;
      dout    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        scl_oe <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (state == IDLE) begin
        if (cmd_valid) begin
          cmd_q            <= cmd;
          din_q            <= cmd_din;
          presc_q          <= prescale;
          cnt              <= prescale;
          state            <= PH_A;
          busy             <= 1'b1;
          {scl_oe, sda_oe} <= phase_drive(cmd, cmd_din, PH_A);
        end
      end else if (!stall) begin
        if (cnt == '0) begin
          cnt <= presc_q;
          if ((state == PH_C) && (cmd_q == CMD_READ)) dout <= sda_i;
          if (state == PH_D) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state            <= nxt_phase;
            {scl_oe, sda_oe} <= phase_drive(cmd_q, din_q, nxt_phase);
          end
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end
  end

endmodule
